uart_hex_formatter: RTL and testbench

- Upstream feeder for the UART transmitter.
- Accepts a binary word on a valid/ready port and emits it as ASCII hexadecimal characters, MSB nibble first, optionally followed by CR LF.
- Emission is on a byte-wide valid/ready port that connects directly to the transmitter's valid/ready/data_to_xmit inputs.
- Runs on the same 16x sampling clock as the transmitter.

---
 rtl/uart_hex_formatter.sv | 148 ++++++++++++++
 tb/tb_uart_hex_formatter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_formatter.sv
// ---------------------------------------------------------------------------
// uart_hex_formatter
//
// Feeds the UART transmitter. Takes one binary word on a valid/ready input
// port and sends it out as ASCII hex characters, most significant nibble
// first. When APPEND_CRLF is set, CR (0x0D) and LF (0x0A) follow the digits.
// The byte-wide output port connects directly to the transmitter's
// valid/ready/data inputs. The block runs on the transmitter's 16x sampling
// clock.
//
// Parameters:
//   NIBBLES     - hex digits per word (1..16); in_data is 4*NIBBLES bits wide
//   APPEND_CRLF - 1: send CR LF after the last digit; 0: send nothing extra
//   UPPERCASE   - 1: digits 10..15 map to 'A'..'F'; 0: map to 'a'..'f'
//
// Ports:
//   uart_sampling_clk - clock, shared with the transmitter
//   reset             - asynchronous, active-low (0 resets, 1 runs)
//   in_valid/in_ready - word handshake; in_ready is high only in IDLE
//   in_data           - word to format
//   out_valid/out_ready - character handshake with the transmitter
//   out_data          - ASCII character, decoded from registered state only
//   busy              - high while a word is being emitted
// ---------------------------------------------------------------------------
module uart_hex_formatter #(
  parameter int NIBBLES     = 8,
  parameter int APPEND_CRLF = 1,
  parameter int UPPERCASE   = 1
) (
  input  logic                   uart_sampling_clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEX,
    S_CR,
    S_LF
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [4*NIBBLES-1:0]   r_word;
  logic [4*NIBBLES-1:0]   w_nextWord;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_nextIdx;
  logic [3:0]             w_nibble;
  logic [7:0]             w_hexChar;

  always_ff @(posedge uart_sampling_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nextState;
      r_word  <= w_nextWord;
      r_idx   <= w_nextIdx;
    end
  end

  // The terminal idx==0 check runs before any decrement, so idx never wraps.
  // With NIBBLES=1, IDX_LAST is 0, which keeps idx at a constant 0.
  always_comb begin
    w_nextState = r_state;
    w_nextWord  = r_word;
    w_nextIdx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_nextState = S_HEX;
          w_nextWord  = in_data;
          w_nextIdx   = IDX_LAST;
        end
      end
      S_HEX: begin
        if (out_ready) begin
          if (r_idx != '0) begin
            w_nextIdx = r_idx - 1'b1;
          end else if (APPEND_CRLF != 0) begin
            w_nextState = S_CR;
          end else begin
            w_nextState = S_IDLE;
          end
        end
      end
      S_CR: begin
        if (out_ready) begin
          w_nextState = S_LF;
        end
      end
      S_LF: begin
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Nibble select by comparison rather than a variable part-select. This
  // stays width-clean for any NIBBLES, including non-powers of two.
  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble = r_word[4*i +: 4];
      end
    end
  end

  // 0x37 and 0x57 are 'A'-10 and 'a'-10, so one add covers the whole letter range.
  always_comb begin
    if (w_nibble < 4'd10) begin
      w_hexChar = 8'h30 + {4'h0, w_nibble};
    end else if (UPPERCASE != 0) begin
      w_hexChar = 8'h37 + {4'h0, w_nibble};
    end else begin
      w_hexChar = 8'h57 + {4'h0, w_nibble};
    end
  end

  always_comb begin
    case (r_state)
      S_HEX:   out_data = w_hexChar;
      S_CR:    out_data = 8'h0D;
      S_LF:    out_data = 8'h0A;
      default: out_data = 8'h00;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state != S_IDLE);
  assign busy      = out_valid;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_formatter
//
// Directed bench for uart_hex_formatter. It drives two instances:
//   dutA: default build (8 nibbles, CR LF appended, uppercase digits)
//   dutB: 2 nibbles, no CR LF, lowercase digits
// Inputs are driven, and outputs sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_hex_formatter;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;

  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inData = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [7:0]  outData;
  logic        busy;

  logic        bInValid = 1'b0;
  logic        bInReady;
  logic [7:0]  bInData = '0;
  logic        bOutValid;
  logic        bOutReady = 1'b1;
  logic [7:0]  bOutData;
  logic        bBusy;

  int checks = 0;
  int errors = 0;

  logic [7:0] expBasic  [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
  logic [7:0] expDead   [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] expZero   [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] expPair   [20] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A,
                                 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  uart_hex_formatter dutA (
    .uart_sampling_clk (clk),
    .reset             (resetN),
    .in_valid          (inValid),
    .in_ready          (inReady),
    .in_data           (inData),
    .out_valid         (outValid),
    .out_ready         (outReady),
    .out_data          (outData),
    .busy              (busy)
  );

  uart_hex_formatter #(
    .NIBBLES     (2),
    .APPEND_CRLF (0),
    .UPPERCASE   (0)
  ) dutB (
    .uart_sampling_clk (clk),
    .reset             (resetN),
    .in_valid          (bInValid),
    .in_ready          (bInReady),
    .in_data           (bInData),
    .out_valid         (bOutValid),
    .out_ready         (bOutReady),
    .out_data          (bOutData),
    .busy              (bBusy)
  );

  // Reset state of both instances while reset is held low
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({inReady, outValid, busy, outData} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_a: rdy/vld/busy/data got %b%b%b %h expected 100 00", inReady, outValid, busy, outData);
    end
    checks++;
    if ({bInReady, bOutValid, bBusy, bOutData} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_b: rdy/vld/busy/data got %b%b%b %h expected 100 00", bInReady, bOutValid, bBusy, bOutData);
    end
    resetN = 1'b1;
  endtask

  // Basic emission with out_ready tied high
  task automatic test_basic();
    outReady = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle: in_ready/out_valid got %b/%b expected 1/0", inReady, outValid);
    end
    inValid = 1'b1;
    inData  = 32'h1234ABCD;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inValid = 1'b0;
      checks++;
      if (outValid !== 1'b1 || busy !== 1'b1 || inReady !== 1'b0 || outData !== expBasic[k]) begin
        errors++;
        $display("[TB] FAIL basic_char%0d: vld/busy/rdy %b%b%b data %h expected 110 data %h",
                 k, outValid, busy, inReady, outData, expBasic[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_end: vld/rdy/busy got %b%b%b expected 010", outValid, inReady, busy);
    end
  endtask

  // Random backpressure, with out_ready high about 30% of cycles
  task automatic test_backpressure();
    int         n;
    int         cycles;
    logic       rdy;
    logic       prevStall;
    logic [7:0] prevData;
    n = 0;
    cycles = 0;
    prevStall = 1'b0;
    prevData = 8'h00;
    outReady = 1'b0;
    inValid = 1'b1;
    inData  = 32'h1234ABCD;
    @(negedge clk);
    inValid = 1'b0;
    while (n < 10 && cycles < 400) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      if (prevStall) begin
        checks++;
        if (outValid !== 1'b1 || outData !== prevData) begin
          errors++;
          $display("[TB] FAIL bp_stable: vld %b data %h expected 1 data %h", outValid, outData, prevData);
        end
      end
      rdy = ($urandom_range(0, 9) < 3);
      outReady = rdy;
      if (outValid === 1'b1 && rdy) begin
        checks++;
        if (outData !== expBasic[n]) begin
          errors++;
          $display("[TB] FAIL bp_char%0d: got %h expected %h", n, outData, expBasic[n]);
        end
        n++;
      end
      prevStall = (outValid === 1'b1) && !rdy;
      prevData  = outData;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d characters expected 10", n);
    end
    @(negedge clk);
    outReady = 1'b1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_end: vld/rdy got %b%b expected 01", outValid, inReady);
    end
  endtask

  // Second instance: 2 nibbles, lowercase digits, no CR LF
  task automatic test_corners();
    logic [7:0] words [2] = '{8'hF0, 8'h0A};
    logic [7:0] exp   [4] = '{8'h66, 8'h30, 8'h30, 8'h61};
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      bInValid = 1'b1;
      bInData  = words[w];
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        bInValid = 1'b0;
        checks++;
        if (bOutValid !== 1'b1 || bOutData !== exp[2*w+k]) begin
          errors++;
          $display("[TB] FAIL corner_w%0d_c%0d: vld %b data %h expected 1 data %h",
                   w, k, bOutValid, bOutData, exp[2*w+k]);
        end
      end
      @(negedge clk);
      checks++;
      if (bOutValid !== 1'b0 || bInReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL corner_end%0d: vld/rdy got %b%b expected 01", w, bOutValid, bInReady);
      end
    end
  endtask

  // Input changes while busy must be ignored; next word taken in first IDLE cycle
  task automatic test_held_input();
    int cycles;
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b1;
    inData  = 32'hDEADBEEF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inData = $urandom;
      checks++;
      if (outValid !== 1'b1 || outData !== expDead[k]) begin
        errors++;
        $display("[TB] FAIL held_char%0d: vld %b data %h expected 1 data %h", k, outValid, outData, expDead[k]);
      end
    end
    @(negedge clk);
    inData = 32'h12345678;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_idle: vld/rdy got %b%b expected 01", outValid, inReady);
    end
    @(negedge clk);
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outData !== 8'h31) begin
      errors++;
      $display("[TB] FAIL held_next: vld %b data %h expected 1 data 31", outValid, outData);
    end
    cycles = 0;
    while (outValid === 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_drain: out_valid got %b expected 0 after %0d cycles", outValid, cycles);
    end
  endtask

  // Asynchronous reset partway through a word
  task automatic test_reset_mid_word();
    logic [7:0] exp3 [3] = '{8'h38, 8'h39, 8'h41};
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b1;
    inData  = 32'h89ABCDEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      inValid = 1'b0;
      checks++;
      if (outValid !== 1'b1 || outData !== exp3[k]) begin
        errors++;
        $display("[TB] FAIL rst_pre%0d: vld %b data %h expected 1 data %h", k, outValid, outData, exp3[k]);
      end
    end
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if ({outValid, inReady, busy, outData} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL rst_async: vld/rdy/busy %b%b%b data %h expected 010 data 00", outValid, inReady, busy, outData);
    end
    inValid = 1'b1;
    inData  = 32'h55555555;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_hold: vld/rdy got %b%b expected 01", outValid, inReady);
    end
    inValid = 1'b0;
    resetN  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (outValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_quiet%0d: out_valid got %b expected 0", k, outValid);
      end
    end
    inValid = 1'b1;
    inData  = 32'h00000000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inValid = 1'b0;
      checks++;
      if (outValid !== 1'b1 || outData !== expZero[k]) begin
        errors++;
        $display("[TB] FAIL rst_after%0d: vld %b data %h expected 1 data %h", k, outValid, outData, expZero[k]);
      end
    end
    @(negedge clk);
  endtask

  // Two words back to back, second held on the input from the start
  task automatic test_back_to_back();
    int n;
    int gaps;
    int cycles;
    n = 0;
    gaps = 0;
    cycles = 0;
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b1;
    inData  = 32'h00000001;
    @(negedge clk);
    inData  = 32'hFFFFFFFF;
    while (n < 20 && cycles < 100) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      if (outValid === 1'b1) begin
        if (n >= 10) inValid = 1'b0;
        checks++;
        if (outData !== expPair[n]) begin
          errors++;
          $display("[TB] FAIL b2b_char%0d: got %h expected %h", n, outData, expPair[n]);
        end
        n++;
      end else begin
        gaps++;
      end
    end
    inValid = 1'b0;
    checks++;
    if (n != 20 || gaps != 1) begin
      errors++;
      $display("[TB] FAIL b2b_count: chars %0d idle %0d expected chars 20 idle 1", n, gaps);
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_end: vld/rdy got %b%b expected 01", outValid, inReady);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_corners();
    test_held_input();
    test_reset_mid_word();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
